// File: rtl/mult_rr_arbiter.sv
// mult_rr_arbiter: round-robin sharing of one 32-bit multiplier; MULT_RR_ARBITER_PERF_EN adds grant/stall counters
module multiplier (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);
  assign p = a * b;
endmodule

module mult_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_prod,
  output logic                 busy
`ifdef MULT_RR_ARBITER_PERF_EN
  ,
  input  logic                 perf_clr,
  output logic [NUM_REQ*16-1:0] grant_cnt,
  output logic [15:0]          stall_cnt
`endif
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic [ID_W-1:0] ptr, win;
  logic found, can_issue, issue;
  logic [31:0] op_a, op_b, prod;
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        win = ID_W'((int'(ptr) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end
  assign can_issue = (state == EMPTY) || rsp_ready;
  assign issue     = found && can_issue;
  assign req_ready = (issue && rst_n) ? NUM_REQ'(1) << win : '0;
  assign op_a      = req_a[win*32 +: 32];
  assign op_b      = req_b[win*32 +: 32];
  assign rsp_valid = (state == FULL);
  assign busy      = |req_valid || rsp_valid;
  multiplier u_mul (.a(op_a), .b(op_b), .p(prod));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      ptr      <= '0;
      rsp_id   <= '0;
      rsp_prod <= '0;
    end else if (issue) begin
      state    <= FULL;
      rsp_prod <= prod;
      rsp_id   <= win;
      ptr      <= ID_W'((int'(win) + 1) % NUM_REQ);
    end else if (rsp_ready) begin
      state <= EMPTY;
    end
  end
`ifdef MULT_RR_ARBITER_PERF_EN
  logic [15:0] gcnt [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    assign grant_cnt[i*16 +: 16] = gcnt[i];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) gcnt[i] <= '0;
      else if (perf_clr) gcnt[i] <= '0;
      else if (issue && win == ID_W'(i) && gcnt[i] != 16'hFFFF) gcnt[i] <= gcnt[i] + 16'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (perf_clr) stall_cnt <= '0;
    else if (state == FULL && !rsp_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_mult_rr_arbiter.sv
// tb_mult_rr_arbiter: randomized and directed checks against a behavioural model of the arbiter
module tb_mult_rr_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] req_valid, req_ready;
  logic [N*32-1:0] req_a, req_b;
  logic rsp_valid, rsp_ready, busy;
  logic [1:0] rsp_id;
  logic [31:0] rsp_prod;
`ifdef MULT_RR_ARBITER_PERF_EN
  logic perf_clr;
  logic [N*16-1:0] grant_cnt;
  logic [15:0] stall_cnt;
`endif
  mult_rr_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_prod(rsp_prod), .busy(busy)
`ifdef MULT_RR_ARBITER_PERF_EN
    , .perf_clr(perf_clr), .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int m_ptr, m_id;
  bit m_full;
  logic [31:0] m_prod;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask
  function automatic int pick();
    if (m_full && !rsp_ready) return -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction
  function automatic logic [31:0] low_prod(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] f;
    f = {32'd0, a} * {32'd0, b};
    return f[31:0];
  endfunction
  task automatic model_reset();
    m_ptr = 0;
    m_id = 0;
    m_full = 0;
    m_prod = '0;
  endtask
  task automatic step(output int w);
    #1;
    w = pick();
    check("req_ready", {60'd0, req_ready}, w < 0 ? 64'd0 : 64'd1 << w);
    check("busy", {63'd0, busy}, {63'd0, (|req_valid) || m_full});
    @(posedge clk);
    if (w >= 0) begin
      m_full = 1;
      m_id = w;
      m_prod = low_prod(req_a[w*32 +: 32], req_b[w*32 +: 32]);
      m_ptr = (w + 1) % N;
    end else if (rsp_ready) m_full = 0;
    #1;
    check("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_full});
    check("rsp_id", {62'd0, rsp_id}, 64'(m_id));
    check("rsp_prod", {32'd0, rsp_prod}, {32'd0, m_prod});
    @(negedge clk);
  endtask
  initial begin
    int w, prev;
    logic [31:0] held;
    bit pend [N];
    rst_n = 0;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    rsp_ready = 0;
`ifdef MULT_RR_ARBITER_PERF_EN
    perf_clr = 0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_id", {62'd0, rsp_id}, 64'd0);
    check("rst_prod", {32'd0, rsp_prod}, 64'd0);
    check("rst_ready", {60'd0, req_ready}, 64'd0);
    rst_n = 1;
    req_valid = '0;
    rsp_ready = 1;
    set_op(2, 32'd7, 32'd6);
    req_valid = 4'b0100;
    #1 check("single_ready", {60'd0, req_ready}, 64'b0100);
    step(w);
    check("single_id", {62'd0, rsp_id}, 64'd2);
    check("single_prod", {32'd0, rsp_prod}, 64'd42);
    req_valid = '0;
    step(w);
    check("single_drain", {63'd0, rsp_valid}, 64'd0);
    for (int i = 0; i < N; i++) set_op(i, 32'(i + 3), 32'(100 + i));
    req_valid = '1;
    step(prev);
    for (int c = 0; c < 6; c++) begin
      step(w);
      check("rr_rotate", 64'(w), 64'((prev + 1) % N));
      prev = w;
    end
    rsp_ready = 0;
    held = rsp_prod;
    for (int c = 0; c < 5; c++) begin
      step(w);
      check("bp_hold", {32'd0, rsp_prod}, {32'd0, held});
    end
    rsp_ready = 1;
    step(w);
    check("bp_regrant", 64'(w >= 0), 64'd1);
    req_valid = '0;
    step(w);
    set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid = 4'b0001;
    step(w);
    check("trunc_ff", {32'd0, rsp_prod}, 64'd1);
    set_op(0, 32'h0001_0000, 32'h0001_0000);
    step(w);
    check("trunc_10000", {32'd0, rsp_prod}, 64'd0);
    set_op(1, 32'hFFFF_FFFD, 32'd5);
    req_valid = 4'b0010;
    step(w);
    check("signed", {32'd0, rsp_prod}, 64'hFFFF_FFF1);
    rsp_ready = 0;
    req_valid = 4'b0100;
    set_op(2, 32'd9, 32'd9);
    step(w);
    rst_n = 0;
    #1;
    check("async_rst_valid", {63'd0, rsp_valid}, 64'd0);
    check("async_rst_ready", {60'd0, req_ready}, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    rsp_ready = 1;
    req_valid = 4'b1010;
    step(w);
    check("rst_ptr", 64'(w), 64'd1);
    req_valid = '0;
    step(w);
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          set_op(i, $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom, $urandom);
        end
        req_valid[i] = pend[i];
      end
      rsp_ready = $urandom_range(0, 3) != 0;
      step(w);
      if (w >= 0) pend[w] = 0;
    end
`ifdef MULT_RR_ARBITER_PERF_EN
    req_valid = '0;
    rsp_ready = 1;
    perf_clr = 1;
    step(w);
    perf_clr = 0;
    check("perf_clr0", {48'd0, stall_cnt}, 64'd0);
    req_valid = 4'b1000;
    set_op(3, 32'd2, 32'd3);
    repeat (10) step(w);
    req_valid = '0;
    rsp_ready = 0;
    repeat (4) step(w);
    check("grant_cnt3", {48'd0, grant_cnt[63:48]}, 64'd10);
    check("grant_cnt0", {48'd0, grant_cnt[15:0]}, 64'd0);
    check("stall_cnt", {48'd0, stall_cnt}, 64'd4);
    perf_clr = 1;
    step(w);
    perf_clr = 0;
    check("perf_clr_g", {{(64 - N*16){1'b0}}, grant_cnt}, 64'd0);
    check("perf_clr_s", {48'd0, stall_cnt}, 64'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
